// File: rtl/ras_circular_pkg.sv
// Shared frontend RAS types and circular pointer helpers.
package ras_circular_pkg;

    localparam int RAS_VLEN  = 64;
    localparam int RAS_PTR_W = 8;
    localparam int RAS_CNT_W = 9;

    // Packed view of valid_o/data_o for frontend consumers.
    typedef struct packed {
        logic                valid;
        logic [RAS_VLEN-1:0] ra;
    } ras_t;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] tp;
        logic [RAS_CNT_W-1:0] cnt;
        logic [RAS_VLEN-1:0]  top;
    } ras_ckpt_t;

    // Explicit compare so non-power-of-two depths wrap without a modulo.
    function automatic logic [31:0] ras_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic logic [31:0] ras_dec(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == 32'd0) ? depth - 32'd1 : ptr - 32'd1;
    endfunction

endpackage

// File: rtl/ras_circular.sv
// Circular return-address stack with saturating occupancy and overflow/underflow flags.
// Define RAS_CHECKPOINT_EN to add a snapshot/restore shadow of {tp, cnt, top}.
module ras_circular
    import ras_circular_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int VLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    input  logic                       snapshot_i,
    input  logic                       restore_i,
    output logic                       valid_o,
    output logic [VLEN-1:0]            data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [VLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tp, tp_n, tp_inc, tp_dec, waddr;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [VLEN-1:0]  wdata;
    logic             we;
    logic             do_push, do_replace;

    assign tp_inc = PTR_W'(ras_inc(32'(tp), 32'(DEPTH)));
    assign tp_dec = PTR_W'(ras_dec(32'(tp), 32'(DEPTH)));

    assign data_o  = mem[tp];
    assign valid_o = (cnt != '0);
    assign count_o = cnt;

    // Call+return on a non-empty stack swaps the top; on an empty stack it is a plain push.
    assign do_replace = push_i && pop_i && (cnt != '0);
    assign do_push    = push_i && !do_replace;

`ifdef RAS_CHECKPOINT_EN
    typedef struct packed {
        logic [PTR_W-1:0] tp;
        logic [CNT_W-1:0] cnt;
        logic [VLEN-1:0]  top;
    } ckpt_t;

    ckpt_t ck;

    // Restore takes priority, so a simultaneous snapshot is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ck <= '0;
        end else if (snapshot_i && !restore_i) begin
            ck <= '{tp: tp, cnt: cnt, top: mem[tp]};
        end
    end
`else
    logic unused_ckpt;
    assign unused_ckpt = snapshot_i ^ restore_i;
`endif

    always_comb begin
        tp_n        = tp;
        cnt_n       = cnt;
        we          = 1'b0;
        waddr       = tp;
        wdata       = data_i;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        if (flush_i) begin
            tp_n  = '0;
            cnt_n = '0;
`ifdef RAS_CHECKPOINT_EN
        end else if (restore_i) begin
            tp_n  = ck.tp;
            cnt_n = ck.cnt;
            we    = 1'b1;
            waddr = ck.tp;
            wdata = ck.top;
`endif
        end else if (do_replace) begin
            we = 1'b1;
        end else if (do_push) begin
            tp_n  = tp_inc;
            we    = 1'b1;
            waddr = tp_inc;
            if (cnt < CNT_W'(DEPTH)) begin
                cnt_n = cnt + CNT_W'(1);
            end else begin
                overflow_o = 1'b1;
            end
        end else if (pop_i) begin
            if (cnt != '0) begin
                tp_n  = tp_dec;
                cnt_n = cnt - CNT_W'(1);
            end else begin
                underflow_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            tp  <= tp_n;
            cnt <= cnt_n;
            if (we) begin
                mem[waddr] <= wdata;
            end
        end
    end

endmodule
